// File: rtl/axi_resp_pkg.sv
// Shared AXI response definitions and the severity-ordered response merge.
// Used by the write-response router and the read-path response merge.
package axi_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Severity rank: EXOKAY < OKAY < SLVERR < DECERR.
    function automatic logic [1:0] resp_rank(input logic [1:0] r);
        logic [1:0] rank;
        case (r)
            RESP_EXOKAY: rank = 2'd0;
            RESP_OKAY:   rank = 2'd1;
            RESP_SLVERR: rank = 2'd2;
            default:     rank = 2'd3;
        endcase
        return rank;
    endfunction

    // Returns the more severe of two response codes; EXOKAY is the neutral element.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (resp_rank(a) >= resp_rank(b)) ? a : b;
    endfunction

endpackage

// File: rtl/write_resp_router.sv
// Write-response (B channel) router.
// Queues the owning master ID of every completed W burst (or burst part) and
// steers slave B responses back to masters in that order. Responses for
// non-final split parts are absorbed and their worst code is merged into the
// single B handed to the master.
// Ports:
//   ACLK, ARESET                  clock, asynchronous active-high reset
//   Push, Push_Master_ID,
//   Push_Is_Split_Part            enqueue one completed burst / burst part
//   S_BVALID, S_BRESP, S_BREADY   slave-side B channel
//   M_BVALID, M_BRESP, M_BREADY   master-side B channel (one-hot valid)
//   Resp_Master_ID                master ID of the head entry
//   Queue_Is_Full, Queue_Is_Empty occupancy flags
//   Overflow_Err                  sticky: a push was dropped
module write_resp_router
    import axi_resp_pkg::*;
#(
    parameter int unsigned Masters_Num = 2,
    parameter int unsigned ID_Size     = (Masters_Num > 1) ? $clog2(Masters_Num) : 1,
    parameter int unsigned Depth       = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   Push,
    input  logic [ID_Size-1:0]     Push_Master_ID,
    input  logic                   Push_Is_Split_Part,
    input  logic                   S_BVALID,
    input  logic [1:0]             S_BRESP,
    output logic                   S_BREADY,
    output logic [Masters_Num-1:0] M_BVALID,
    output logic [1:0]             M_BRESP,
    input  logic [Masters_Num-1:0] M_BREADY,
    output logic [ID_Size-1:0]     Resp_Master_ID,
    output logic                   Queue_Is_Full,
    output logic                   Queue_Is_Empty,
    output logic                   Overflow_Err
);

    localparam int unsigned PTR_W = $clog2(Depth);

    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ID_Size-1:0]   id_mem_q [Depth];
    logic [ID_Size-1:0]   id_mem_d [Depth];
    logic [Depth-1:0]     split_mem_q, split_mem_d;
    logic [1:0]           resp_acc_q, resp_acc_d;
    logic                 overflow_q, overflow_d;

    logic [PTR_W-1:0]     rd_idx, wr_idx;
    logic [ID_Size-1:0]   head_id;
    logic                 head_split;
    logic                 pop, push_acc;

    // Occupancy flags: extra pointer MSB distinguishes full from empty.
    assign rd_idx         = rd_ptr_q[PTR_W-1:0];
    assign wr_idx         = wr_ptr_q[PTR_W-1:0];
    assign Queue_Is_Empty = (rd_ptr_q == wr_ptr_q);
    assign Queue_Is_Full  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) && (rd_idx == wr_idx);

    assign head_id        = id_mem_q[rd_idx];
    assign head_split     = split_mem_q[rd_idx];
    assign Resp_Master_ID = head_id;
    assign Overflow_Err   = overflow_q;
    assign M_BRESP        = resp_merge(resp_acc_q, S_BRESP);

    // Zero-latency routing: split parts are absorbed, final parts go to the owner.
    always_comb begin
        S_BREADY = 1'b0;
        M_BVALID = '0;
        if (!Queue_Is_Empty) begin
            if (head_split) begin
                S_BREADY = 1'b1;
            end else begin
                for (int unsigned i = 0; i < Masters_Num; i++) begin
                    if (head_id == ID_Size'(i)) begin
                        M_BVALID[i] = S_BVALID;
                        S_BREADY    = M_BREADY[i];
                    end
                end
            end
        end
    end

    // A push into a full queue is still accepted when a pop frees a slot in the same cycle.
    assign pop      = S_BVALID & S_BREADY;
    assign push_acc = Push & (~Queue_Is_Full | pop);

    // Next-state: pointers, storage, response accumulator, sticky overflow.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        id_mem_d    = id_mem_q;
        split_mem_d = split_mem_q;
        resp_acc_d  = resp_acc_q;
        overflow_d  = overflow_q;

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + (PTR_W + 1)'(1);
            resp_acc_d = head_split ? resp_merge(resp_acc_q, S_BRESP) : RESP_EXOKAY;
        end

        if (push_acc) begin
            id_mem_d[wr_idx]    = Push_Master_ID;
            split_mem_d[wr_idx] = Push_Is_Split_Part;
            wr_ptr_d            = wr_ptr_q + (PTR_W + 1)'(1);
        end else if (Push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            split_mem_q <= '0;
            resp_acc_q  <= RESP_EXOKAY;
            overflow_q  <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            split_mem_q <= split_mem_d;
            resp_acc_q  <= resp_acc_d;
            overflow_q  <= overflow_d;
            id_mem_q    <= id_mem_d;
        end
    end

endmodule

// File: tb/tb_write_resp_router.sv
// Self-checking bench for write_resp_router: directed scenarios plus a
// randomized run compared cycle by cycle against a queue-based reference.
module tb_write_resp_router;

    localparam int MN    = 2;
    localparam int IDW   = 1;
    localparam int DEPTH = 4;

    logic            ACLK;
    logic            ARESET;
    logic            Push;
    logic [IDW-1:0]  Push_Master_ID;
    logic            Push_Is_Split_Part;
    logic            S_BVALID;
    logic [1:0]      S_BRESP;
    logic            S_BREADY;
    logic [MN-1:0]   M_BVALID;
    logic [1:0]      M_BRESP;
    logic [MN-1:0]   M_BREADY;
    logic [IDW-1:0]  Resp_Master_ID;
    logic            Queue_Is_Full;
    logic            Queue_Is_Empty;
    logic            Overflow_Err;

    int n_checks = 0;
    int n_fail   = 0;

    write_resp_router #(.Masters_Num(MN), .ID_Size(IDW), .Depth(DEPTH)) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .Push               (Push),
        .Push_Master_ID     (Push_Master_ID),
        .Push_Is_Split_Part (Push_Is_Split_Part),
        .S_BVALID           (S_BVALID),
        .S_BRESP            (S_BRESP),
        .S_BREADY           (S_BREADY),
        .M_BVALID           (M_BVALID),
        .M_BRESP            (M_BRESP),
        .M_BREADY           (M_BREADY),
        .Resp_Master_ID     (Resp_Master_ID),
        .Queue_Is_Full      (Queue_Is_Full),
        .Queue_Is_Empty     (Queue_Is_Empty),
        .Overflow_Err       (Overflow_Err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- reference model ----------------
    typedef struct {
        int id;
        bit split;
    } ent_t;

    ent_t       mq[$];
    logic [1:0] m_acc;
    bit         m_ovf;

    // Worse of two codes by position in the severity list.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] order [4];
        int pa, pb;
        order = '{2'b01, 2'b00, 2'b10, 2'b11};
        pa = 0;
        pb = 0;
        for (int k = 0; k < 4; k++) begin
            if (order[k] == a) pa = k;
            if (order[k] == b) pb = k;
        end
        return (pa >= pb) ? a : b;
    endfunction

    function automatic bit model_sready(input logic [MN-1:0] mr);
        if (mq.size() == 0) return 1'b0;
        if (mq[0].split) return 1'b1;
        return mr[mq[0].id];
    endfunction

    function automatic logic [MN-1:0] model_mvalid(input logic sv);
        logic [MN-1:0] v;
        v = '0;
        if (mq.size() != 0 && !mq[0].split && sv) v[mq[0].id] = 1'b1;
        return v;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_clock();
        bit   pop_now, full_now;
        ent_t e;
        pop_now  = S_BVALID && model_sready(M_BREADY);
        full_now = (mq.size() == DEPTH);
        if (pop_now) begin
            m_acc = mq[0].split ? worse(m_acc, S_BRESP) : 2'b01;
            void'(mq.pop_front());
        end
        if (Push) begin
            if (!full_now || pop_now) begin
                e.id    = int'(Push_Master_ID);
                e.split = Push_Is_Split_Part;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_acc = 2'b01;
        m_ovf = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        Push               = 1'b0;
        Push_Master_ID     = '0;
        Push_Is_Split_Part = 1'b0;
        S_BVALID           = 1'b0;
        S_BRESP            = 2'b01;
        M_BREADY           = '0;
    endtask

    task automatic push_one(input int id, input bit split);
        Push               = 1'b1;
        Push_Master_ID     = IDW'(id);
        Push_Is_Split_Part = split;
        tick();
        Push               = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        #2;
        ARESET = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        S_BRESP = 2'b10;
        ARESET  = 1'b1;
        #2;
        n_checks++;
        if (Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", Queue_Is_Empty); end
        n_checks++;
        if (Queue_Is_Full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", Queue_Is_Full); end
        n_checks++;
        if (S_BREADY !== 1'b0 || M_BVALID !== 2'b00) begin n_fail++; $display("FAIL reset_handshake: sready %b mvalid %b want 0 00", S_BREADY, M_BVALID); end
        n_checks++;
        if (Overflow_Err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", Overflow_Err); end
        n_checks++;
        if (Resp_Master_ID !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", Resp_Master_ID); end
        n_checks++;
        if (M_BRESP !== 2'b10) begin n_fail++; $display("FAIL reset_bresp: got %b want 10", M_BRESP); end
        ARESET = 1'b0;
        S_BRESP = 2'b01;
        tick();
    endtask

    task automatic test_single();
        push_one(1, 1'b0);
        n_checks++;
        if (Queue_Is_Empty !== 1'b0 || Resp_Master_ID !== 1'b1) begin n_fail++; $display("FAIL single_queued: empty %b id %0d want 0 1", Queue_Is_Empty, Resp_Master_ID); end
        S_BVALID = 1'b1;
        S_BRESP  = 2'b00;
        M_BREADY = 2'b10;
        #1;
        n_checks++;
        if (M_BVALID !== 2'b10 || S_BREADY !== 1'b1) begin n_fail++; $display("FAIL single_route: mvalid %b sready %b want 10 1", M_BVALID, S_BREADY); end
        n_checks++;
        if (M_BRESP !== 2'b00) begin n_fail++; $display("FAIL single_bresp: got %b want 00", M_BRESP); end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL single_popped: empty %b want 1", Queue_Is_Empty); end
    endtask

    task automatic test_ordering();
        int ids [3];
        int idx;
        logic [MN-1:0] mv_exp;
        ids = '{0, 1, 0};
        push_one(0, 1'b0);
        push_one(1, 1'b0);
        push_one(0, 1'b0);
        idx      = 0;
        S_BVALID = 1'b1;
        S_BRESP  = 2'b00;
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            M_BREADY = MN'($urandom_range(0, 3));
            #1;
            mv_exp = '0;
            mv_exp[ids[idx]] = 1'b1;
            n_checks++;
            if (M_BVALID !== mv_exp) begin n_fail++; $display("FAIL order_mvalid[%0d]: got %b want %b", idx, M_BVALID, mv_exp); end
            n_checks++;
            if (S_BREADY !== M_BREADY[ids[idx]]) begin n_fail++; $display("FAIL order_sready[%0d]: got %b want %b", idx, S_BREADY, M_BREADY[ids[idx]]); end
            if (M_BREADY[ids[idx]]) idx++;
            tick();
        end
        n_checks++;
        if (idx !== 3) begin n_fail++; $display("FAIL order_count: delivered %0d want 3", idx); end
        idle_inputs();
        #1;
        n_checks++;
        if (Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL order_drained: empty %b want 1", Queue_Is_Empty); end
    endtask

    task automatic test_split_merge();
        logic [1:0] resps [3];
        resps = '{2'b00, 2'b10, 2'b00};
        push_one(1, 1'b1);
        push_one(1, 1'b1);
        push_one(1, 1'b0);
        S_BVALID = 1'b1;
        M_BREADY = 2'b10;
        for (int k = 0; k < 2; k++) begin
            S_BRESP = resps[k];
            #1;
            n_checks++;
            if (M_BVALID !== 2'b00 || S_BREADY !== 1'b1) begin n_fail++; $display("FAIL split_absorb[%0d]: mvalid %b sready %b want 00 1", k, M_BVALID, S_BREADY); end
            tick();
        end
        S_BRESP = resps[2];
        #1;
        n_checks++;
        if (M_BVALID !== 2'b10 || M_BRESP !== 2'b10) begin n_fail++; $display("FAIL split_final: mvalid %b bresp %b want 10 10", M_BVALID, M_BRESP); end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (M_BRESP !== 2'b01 || Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL split_acc_cleared: bresp %b empty %b want 01 1", M_BRESP, Queue_Is_Empty); end
    endtask

    task automatic test_full_overflow();
        int exp_ids [4];
        int pops;
        exp_ids = '{1, 0, 1, 1};
        for (int k = 0; k < DEPTH; k++) push_one(k % 2, 1'b0);
        n_checks++;
        if (Queue_Is_Full !== 1'b1 || Overflow_Err !== 1'b0) begin n_fail++; $display("FAIL full_set: full %b ovf %b want 1 0", Queue_Is_Full, Overflow_Err); end
        push_one(0, 1'b0);
        n_checks++;
        if (Overflow_Err !== 1'b1 || Queue_Is_Full !== 1'b1) begin n_fail++; $display("FAIL full_drop: ovf %b full %b want 1 1", Overflow_Err, Queue_Is_Full); end
        S_BVALID = 1'b1;
        S_BRESP  = 2'b00;
        M_BREADY = 2'b11;
        Push           = 1'b1;
        Push_Master_ID = 1'b1;
        #1;
        n_checks++;
        if (S_BREADY !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b want 1", S_BREADY); end
        tick();
        Push = 1'b0;
        #1;
        n_checks++;
        if (Queue_Is_Full !== 1'b1) begin n_fail++; $display("FAIL full_push_pop: full %b want 1", Queue_Is_Full); end
        pops = 0;
        for (int cyc = 0; cyc < 10 && !Queue_Is_Empty; cyc++) begin
            n_checks++;
            if (pops < 4 && Resp_Master_ID !== IDW'(exp_ids[pops])) begin n_fail++; $display("FAIL full_drain_id[%0d]: got %0d want %0d", pops, Resp_Master_ID, exp_ids[pops]); end
            pops++;
            tick();
        end
        n_checks++;
        if (pops !== 4 || Overflow_Err !== 1'b1) begin n_fail++; $display("FAIL full_drain_count: pops %0d ovf %b want 4 1", pops, Overflow_Err); end
        idle_inputs();
        #1;
    endtask

    task automatic test_early_resp();
        S_BVALID = 1'b1;
        S_BRESP  = 2'b11;
        M_BREADY = 2'b11;
        #1;
        n_checks++;
        if (S_BREADY !== 1'b0 || M_BVALID !== 2'b00 || Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL early_stall: sready %b mvalid %b empty %b want 0 00 1", S_BREADY, M_BVALID, Queue_Is_Empty); end
        push_one(0, 1'b0);
        n_checks++;
        if (M_BVALID !== 2'b01 || S_BREADY !== 1'b1 || M_BRESP !== 2'b11) begin n_fail++; $display("FAIL early_complete: mvalid %b sready %b bresp %b want 01 1 11", M_BVALID, S_BREADY, M_BRESP); end
        tick();
        n_checks++;
        if (Queue_Is_Empty !== 1'b1) begin n_fail++; $display("FAIL early_popped: empty %b want 1", Queue_Is_Empty); end
        idle_inputs();
        #1;
    endtask

    task automatic test_reset_mid();
        push_one(0, 1'b1);
        push_one(1, 1'b0);
        push_one(0, 1'b0);
        S_BVALID = 1'b1;
        S_BRESP  = 2'b11;
        tick();
        S_BVALID = 1'b0;
        S_BRESP  = 2'b01;
        #1;
        n_checks++;
        if (M_BRESP !== 2'b11 || Queue_Is_Empty !== 1'b0) begin n_fail++; $display("FAIL mid_acc: bresp %b empty %b want 11 0", M_BRESP, Queue_Is_Empty); end
        M_BREADY = 2'b11;
        S_BVALID = 1'b1;
        #1;
        ARESET = 1'b1;
        #1;
        n_checks++;
        if (Queue_Is_Empty !== 1'b1 || M_BVALID !== 2'b00 || Overflow_Err !== 1'b0 || S_BREADY !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: empty %b mvalid %b ovf %b sready %b want 1 00 0 0", Queue_Is_Empty, M_BVALID, Overflow_Err, S_BREADY);
        end
        n_checks++;
        if (M_BRESP !== 2'b01 || Resp_Master_ID !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bresp: bresp %b id %0d want 01 0", M_BRESP, Resp_Master_ID); end
        idle_inputs();
        #1;
        ARESET = 1'b0;
        tick();
        push_one(1, 1'b0);
        S_BVALID = 1'b1;
        S_BRESP  = 2'b10;
        M_BREADY = 2'b10;
        #1;
        n_checks++;
        if (M_BVALID !== 2'b10 || M_BRESP !== 2'b10 || S_BREADY !== 1'b1) begin n_fail++; $display("FAIL mid_fresh: mvalid %b bresp %b sready %b want 10 10 1", M_BVALID, M_BRESP, S_BREADY); end
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic test_random();
        logic [MN-1:0] mv_exp;
        idle_inputs();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            Push               = ($urandom_range(0, 99) < 55);
            Push_Master_ID     = IDW'($urandom_range(0, MN - 1));
            Push_Is_Split_Part = ($urandom_range(0, 3) == 0);
            S_BVALID           = ($urandom_range(0, 99) < 50);
            S_BRESP            = 2'($urandom_range(0, 3));
            M_BREADY           = MN'($urandom_range(0, 3));
            #1;
            mv_exp = model_mvalid(S_BVALID);
            n_checks++;
            if (M_BVALID !== mv_exp) begin n_fail++; $display("FAIL rand_mvalid @%0d: got %b want %b", cyc, M_BVALID, mv_exp); end
            n_checks++;
            if (S_BREADY !== model_sready(M_BREADY)) begin n_fail++; $display("FAIL rand_sready @%0d: got %b want %b", cyc, S_BREADY, model_sready(M_BREADY)); end
            n_checks++;
            if (M_BRESP !== worse(m_acc, S_BRESP)) begin n_fail++; $display("FAIL rand_bresp @%0d: got %b want %b", cyc, M_BRESP, worse(m_acc, S_BRESP)); end
            n_checks++;
            if (Queue_Is_Empty !== (mq.size() == 0) || Queue_Is_Full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand_flags @%0d: empty %b full %b want size %0d", cyc, Queue_Is_Empty, Queue_Is_Full, mq.size());
            end
            n_checks++;
            if (Overflow_Err !== m_ovf) begin n_fail++; $display("FAIL rand_ovf @%0d: got %b want %b", cyc, Overflow_Err, m_ovf); end
            if (mq.size() != 0) begin
                n_checks++;
                if (Resp_Master_ID !== IDW'(mq[0].id)) begin n_fail++; $display("FAIL rand_head @%0d: got %0d want %0d", cyc, Resp_Master_ID, mq[0].id); end
            end
            model_clock();
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        ARESET = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_ordering();
        test_split_merge();
        test_full_overflow();
        test_early_resp();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_resp_router.md
Name: write_resp_router

Overview:
- Routes write responses (B channel) from a slave port back to the issuing master, in write-data completion order.
- Sits after the write-data ordering stage: each completed W burst pushes its master ID here; each accepted B response pops one entry.
- Split bursts are handled by absorbing the responses of non-final parts. The worst response across all parts is merged into the single B delivered to the master.

Parameters:
- Masters_Num, 2, number of master ports routed.
- ID_Size, $clog2(Masters_Num), master ID width (minimum 1).
- Depth, 4, outstanding-response FIFO entries; must be a power of 2, ≥2.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- Push  in  1  write data of one burst (or burst part) finished; enqueue one entry.
- Push_Master_ID  in  ID_Size  master that owns the finished burst.
- Push_Is_Split_Part  in  1  1 = non-final part of a split burst (response absorbed); 0 = final part or unsplit burst.
- S_BVALID  in  1  slave response valid.
- S_BRESP  in  2  slave response code.
- S_BREADY  out  1  ready to slave.
- M_BVALID  out  Masters_Num  one-hot response valid to masters.
- M_BRESP  out  2  merged response, common to all masters.
- M_BREADY  in  Masters_Num  per-master ready.
- Resp_Master_ID  out  ID_Size  head-entry master ID.
- Queue_Is_Full  out  1  Depth entries outstanding.
- Queue_Is_Empty  out  1  no entries outstanding.
- Overflow_Err  out  1  sticky: a push was dropped.

Behaviour:
- FIFO storage:
  - Entry = {master ID, split flag}.
  - Read_Ptr and Write_Ptr are log2(Depth)+1 bits wide and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the lower bits are equal.
  - Both flags are combinational from the pointers.
- Push_Acc = Push & (!Queue_Is_Full | Pop). On Push_Acc, the entry is written at Write_Ptr and Write_Ptr increments.
- Dropped push: Push while full with no Pop in the same cycle is dropped and sets Overflow_Err, which holds until reset.
- Head entry = entry at Read_Ptr. Resp_Master_ID shows the head ID; its value while empty is don't-care.
- Routing, all combinational, zero latency:
  - Empty: S_BREADY=0 and M_BVALID=0. A B response arriving early stalls the slave; no error is raised.
  - Head split flag = 1: S_BREADY=1 and M_BVALID=0. The response is absorbed into the accumulator.
  - Head split flag = 0: M_BVALID[head ID]=S_BVALID (all other bits 0) and S_BREADY=M_BREADY[head ID].
- Pop = S_BVALID & S_BREADY. On Pop, Read_Ptr increments.
- Response merge:
  - Severity order: EXOKAY(01) < OKAY(00) < SLVERR(10) < DECERR(11).
  - Merge(a,b) returns the more severe of the two codes.
  - Resp_Acc is a 2-bit register; reset value is 01, the neutral element.
  - Pop of a split entry: Resp_Acc <= Merge(Resp_Acc,S_BRESP).
  - Pop of a final entry: Resp_Acc <= 01.
  - M_BRESP = Merge(Resp_Acc,S_BRESP) at all times.
- Simultaneous push and pop: both pointers advance and occupancy is unchanged. This is legal when full, and when empty only if the push lands first (pop cannot happen while empty).
- Reset, asynchronous, takes effect at any time including mid-burst:
  - Pointers = 0 and storage = 0.
  - Resp_Acc = 01 and Overflow_Err = 0.
  - Outputs: S_BREADY=0, M_BVALID=0, M_BRESP=S_BRESP merged with 01 (i.e. S_BRESP), Queue_Is_Empty=1, Queue_Is_Full=0, Resp_Master_ID=0.
- Masters must not depend on the value of M_BRESP while M_BVALID is low.

Decomposition:
- Shared package axi_resp_pkg holds:
  - localparams RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - function resp_merge(a,b) implementing the severity order, reused by the read-path merge.
- Single module; no sub-module. The FIFO is too small and too specialised to split out.

Test Plan:
- Single response: push ID=1 (split=0), then S_BVALID with BRESP=00 and M_BREADY=2'b10 → M_BVALID=2'b10 and S_BREADY=1 in the same cycle, entry pops, Queue_Is_Empty=1 next cycle.
- Ordering and backpressure: push IDs 0,1,0 with S_BVALID held and M_BREADY toggling → responses reach masters 0,1,0 in order; S_BREADY follows the selected M_BREADY every cycle.
- Split merge: push ID=1 split=1, ID=1 split=1, ID=1 split=0; slave returns 00, 10, 00 → first two absorbed with M_BVALID=0; third gives M_BVALID=2'b10, M_BRESP=10; Resp_Acc=01 after.
- Full queue: 4 pushes with no B → Queue_Is_Full=1. A 5th push alone sets Overflow_Err=1 and the pointer is unchanged. A 5th push together with a Pop is accepted and Full stays 1.
- Empty with early response: S_BVALID=1 while empty → S_BREADY=0 and M_BVALID=0. After a push of ID=0, the response completes the next cycle.
- Reset mid-operation: assert ARESET with 2 entries outstanding and Resp_Acc=11 → immediately Empty=1, M_BVALID=0, Overflow_Err=0; after release, a fresh push/response pair routes correctly with M_BRESP=S_BRESP.
